cmt_usart_fifo_bridge: RTL

//  8251-compatible CMT USART register block, successor to the single-byte CMT link, with a
//  TX FIFO (Z80 -> Nios2) and an RX FIFO (Nios2 -> Z80), both parametrised in width and depth.

---
 rtl/cmt_usart_fifo_bridge.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmt_usart_fifo_bridge.sv
// -----------------------------------------------------------------------------
// cmt_usart_fifo_bridge
//
// 8251-style CMT USART register block between the Z80 I/O decode
// (data port 20h, control port 21h) and the Nios2 CMT driver.
//   - TX FIFO: Z80 data writes -> Nios2 reads
//   - RX FIFO: Nios2 writes    -> Z80 data reads
//   - Mode/command sequencing, sticky overrun flag (OE), fill levels and an
//     internal reset command (IR) that flushes both FIFOs.
//
// Ports
//   I_CLK, I_RST          clock, asynchronous active-high reset
//   I_DATA_EN             Z80 data port select (level)
//   I_CONTROL_EN          Z80 control port select (level)
//   I_WE, I_RD            Z80 write / read qualifiers (level)
//   I_DATA                Z80 write data
//   O_DATA                RX FIFO byte returned on a Z80 data read
//   O_CONTROL_DATA        status byte returned on a Z80 control read
//   O_MODE                last mode byte written
//   I_MCU_WR, I_MCU_RD    Nios2 RX push / TX pop, one-cycle pulses
//   I_MCU_DATA            Nios2 write data
//   O_MCU_DATA            TX FIFO byte returned on a Nios2 read
//   O_TX_LEVEL/O_RX_LEVEL FIFO occupancy, 0..depth
//   O_CMT_SAVE/O_CMT_LOAD command bits TXEN / RXE
// -----------------------------------------------------------------------------
module cmt_usart_fifo_bridge #(
    parameter int DATA_W = 8,
    parameter int TX_AW  = 4,
    parameter int RX_AW  = 4
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_DATA_EN,
    input  logic              I_CONTROL_EN,
    input  logic              I_WE,
    input  logic              I_RD,
    input  logic [DATA_W-1:0] I_DATA,
    output logic [DATA_W-1:0] O_DATA,
    output logic [7:0]        O_CONTROL_DATA,
    output logic [7:0]        O_MODE,
    input  logic              I_MCU_WR,
    input  logic              I_MCU_RD,
    input  logic [DATA_W-1:0] I_MCU_DATA,
    output logic [DATA_W-1:0] O_MCU_DATA,
    output logic [TX_AW:0]    O_TX_LEVEL,
    output logic [RX_AW:0]    O_RX_LEVEL,
    output logic              O_CMT_SAVE,
    output logic              O_CMT_LOAD
);

    localparam int TX_DEPTH = 1 << TX_AW;
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam logic [TX_AW:0] TX_FULL_LVL = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_FULL_LVL = {1'b1, {RX_AW{1'b0}}};

    typedef enum logic {
        ST_MODE = 1'b0,
        ST_CMD  = 1'b1
    } state_t;

    // Z80 access capture
    logic              data_en_reg, data_en_dly_reg;
    logic              ctrl_en_reg, ctrl_en_dly_reg;
    logic              acc_we_reg, acc_rd_reg;
    logic [DATA_W-1:0] acc_data_reg;

    // Control / output registers
    state_t            state_reg, state_next;
    logic [7:0]        mode_reg, mode_next;
    logic              txen_reg, txen_next;
    logic              rxe_reg, rxe_next;
    logic              oe_reg, oe_next;
    logic [7:0]        ctrl_data_reg, ctrl_data_next;
    logic [DATA_W-1:0] data_out_reg, data_out_next;
    logic [DATA_W-1:0] mcu_data_reg, mcu_data_next;

    // FIFO state
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_ptr_reg, tx_wr_ptr_next, tx_rd_ptr_reg, tx_rd_ptr_next;
    logic [RX_AW-1:0]  rx_wr_ptr_reg, rx_wr_ptr_next, rx_rd_ptr_reg, rx_rd_ptr_next;
    logic [TX_AW:0]    tx_level_reg, tx_level_next;
    logic [RX_AW:0]    rx_level_reg, rx_level_next;

    // Combinational helpers
    logic       data_fire, ctrl_fire;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       rx_overrun, flush, er_clear;
    logic       tx_wr_en, rx_wr_en;
    logic [7:0] status;

    // An access is acted on once: the cycle after the registered select
    // falls, i.e. when the delayed copy is still high but the first is low.
    assign data_fire = data_en_dly_reg & ~data_en_reg;
    assign ctrl_fire = ctrl_en_dly_reg & ~ctrl_en_reg;

    assign tx_full  = (tx_level_reg == TX_FULL_LVL);
    assign tx_empty = (tx_level_reg == '0);
    assign rx_full  = (rx_level_reg == RX_FULL_LVL);
    assign rx_empty = (rx_level_reg == '0);

    assign status = {3'b000, oe_reg, 1'b0, tx_empty, ~rx_empty, txen_reg & ~tx_full};

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        txen_next      = txen_reg;
        rxe_next       = rxe_reg;
        oe_next        = oe_reg;
        ctrl_data_next = ctrl_data_reg;
        data_out_next  = data_out_reg;
        mcu_data_next  = mcu_data_reg;
        flush          = 1'b0;
        er_clear       = 1'b0;

        // Full/empty come from start-of-cycle levels, so a pop never frees
        // room for a same-cycle push and a push never feeds a same-cycle pop.
        tx_push    = data_fire & acc_we_reg & ~tx_full;
        tx_pop     = I_MCU_RD & ~tx_empty;
        rx_push    = I_MCU_WR & rxe_reg & ~rx_full;
        rx_pop     = data_fire & acc_rd_reg & ~rx_empty;
        rx_overrun = I_MCU_WR & rxe_reg & rx_full;

        case (state_reg)
            ST_MODE: begin
                if (ctrl_fire && acc_we_reg) begin
                    mode_next  = acc_data_reg[7:0];
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (ctrl_fire && acc_we_reg) begin
                    if (acc_data_reg[6]) begin
                        flush      = 1'b1;
                        state_next = ST_MODE;
                        txen_next  = 1'b0;
                        rxe_next   = 1'b0;
                    end else begin
                        txen_next = acc_data_reg[0];
                        rxe_next  = acc_data_reg[2];
                        er_clear  = acc_data_reg[4];
                    end
                end
            end
            default: state_next = ST_MODE;
        endcase

        // Internal reset beats a new overrun; a new overrun beats ER.
        if (flush) begin
            oe_next = 1'b0;
        end else if (rx_overrun) begin
            oe_next = 1'b1;
        end else if (er_clear) begin
            oe_next = 1'b0;
        end

        if (ctrl_fire && acc_rd_reg) begin
            ctrl_data_next = status;
        end

        if (data_fire && acc_rd_reg) begin
            data_out_next = rx_empty ? '0 : rx_mem[rx_rd_ptr_reg];
        end

        if (I_MCU_RD) begin
            mcu_data_next = tx_empty ? '0 : tx_mem[tx_rd_ptr_reg];
        end

        tx_wr_en = tx_push & ~flush;
        rx_wr_en = rx_push & ~flush;

        if (flush) begin
            tx_wr_ptr_next = '0;
            tx_rd_ptr_next = '0;
            tx_level_next  = '0;
            rx_wr_ptr_next = '0;
            rx_rd_ptr_next = '0;
            rx_level_next  = '0;
        end else begin
            tx_wr_ptr_next = tx_push ? tx_wr_ptr_reg + 1'b1 : tx_wr_ptr_reg;
            tx_rd_ptr_next = tx_pop  ? tx_rd_ptr_reg + 1'b1 : tx_rd_ptr_reg;
            tx_level_next  = tx_level_reg + {{TX_AW{1'b0}}, tx_push}
                                          - {{TX_AW{1'b0}}, tx_pop};
            rx_wr_ptr_next = rx_push ? rx_wr_ptr_reg + 1'b1 : rx_wr_ptr_reg;
            rx_rd_ptr_next = rx_pop  ? rx_rd_ptr_reg + 1'b1 : rx_rd_ptr_reg;
            rx_level_next  = rx_level_reg + {{RX_AW{1'b0}}, rx_push}
                                          - {{RX_AW{1'b0}}, rx_pop};
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            data_en_reg     <= 1'b0;
            data_en_dly_reg <= 1'b0;
            ctrl_en_reg     <= 1'b0;
            ctrl_en_dly_reg <= 1'b0;
            acc_we_reg      <= 1'b0;
            acc_rd_reg      <= 1'b0;
            acc_data_reg    <= '0;
            state_reg       <= ST_MODE;
            mode_reg        <= '0;
            txen_reg        <= 1'b0;
            rxe_reg         <= 1'b0;
            oe_reg          <= 1'b0;
            ctrl_data_reg   <= '0;
            data_out_reg    <= '0;
            mcu_data_reg    <= '0;
            tx_wr_ptr_reg   <= '0;
            tx_rd_ptr_reg   <= '0;
            tx_level_reg    <= '0;
            rx_wr_ptr_reg   <= '0;
            rx_rd_ptr_reg   <= '0;
            rx_level_reg    <= '0;
        end else begin
            data_en_reg     <= I_DATA_EN;
            data_en_dly_reg <= data_en_reg;
            ctrl_en_reg     <= I_CONTROL_EN;
            ctrl_en_dly_reg <= ctrl_en_reg;
            // Qualifiers are sampled throughout the strobe; the last
            // sample before the select drops is the one acted on.
            if (I_DATA_EN || I_CONTROL_EN) begin
                acc_we_reg   <= I_WE;
                acc_rd_reg   <= I_RD;
                acc_data_reg <= I_DATA;
            end
            state_reg       <= state_next;
            mode_reg        <= mode_next;
            txen_reg        <= txen_next;
            rxe_reg         <= rxe_next;
            oe_reg          <= oe_next;
            ctrl_data_reg   <= ctrl_data_next;
            data_out_reg    <= data_out_next;
            mcu_data_reg    <= mcu_data_next;
            tx_wr_ptr_reg   <= tx_wr_ptr_next;
            tx_rd_ptr_reg   <= tx_rd_ptr_next;
            tx_level_reg    <= tx_level_next;
            rx_wr_ptr_reg   <= rx_wr_ptr_next;
            rx_rd_ptr_reg   <= rx_rd_ptr_next;
            rx_level_reg    <= rx_level_next;
        end
    end

    // Storage arrays carry no reset; only pointers and levels define content.
    always_ff @(posedge I_CLK) begin
        if (tx_wr_en) begin
            tx_mem[tx_wr_ptr_reg] <= acc_data_reg;
        end
        if (rx_wr_en) begin
            rx_mem[rx_wr_ptr_reg] <= I_MCU_DATA;
        end
    end

    assign O_DATA         = data_out_reg;
    assign O_CONTROL_DATA = ctrl_data_reg;
    assign O_MODE         = mode_reg;
    assign O_MCU_DATA     = mcu_data_reg;
    assign O_TX_LEVEL     = tx_level_reg;
    assign O_RX_LEVEL     = rx_level_reg;
    assign O_CMT_SAVE     = txen_reg;
    assign O_CMT_LOAD     = rxe_reg;

endmodule
